pfd_sync: RTL and testbench
===========================

Name: pfd_sync

Overview:
- Clocked tri-state phase-frequency detector for the impedance-measurement PLL.
- Compares rising edges of reference input A against feedback input B, which are asynchronous to Clk.
- Drives an UP request QAN (active-low) and a DOWN request QB (active-high) to the downstream charge-pump/loop-filter logic.
- All logic is synchronous to a single clock; edges are detected after synchronisation.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on each of A and B (legal 2..4).
- LOCK_TOL, 2, max UP/DN pulse width in Clk cycles counted as "in phase" (used only with LOCK_DET_EN).
- LOCK_COUNT, 8, consecutive in-phase comparisons required to assert Lock (used only with LOCK_DET_EN).
- CNT_W, 8, width of the internal pulse-width and lock counters.

Ports:
- Clk, input, 1, system clock; all flops on rising edge.
- Reset, input, 1, synchronous active-high reset.
- A, input, 1, reference signal, asynchronous to Clk.
- B, input, 1, feedback signal, asynchronous to Clk.
- QAN, output, 1, UP request, active-low, registered.
- QB, output, 1, DOWN request, active-high, registered.
- Lock, output, 1, lock indicator, registered; present only with LOCK_DET_EN.

Behaviour:
- Synchronisers: each of A and B passes through a SYNC_STAGES flop chain.
- Edge history: a one-flop history register follows each synchroniser output.
- rise_a = syncA & ~histA; rise_b likewise.
- Synchroniser and history flops are NOT reset; they keep sampling during Reset, so a level already high at reset release is not an edge.
- Reset must be held for at least SYNC_STAGES+1 cycles.
- State machine, 3 states: IDLE (QAN=1, QB=0), UP (QAN=0, QB=0), DN (QAN=1, QB=1).
- State QAN=0 with QB=1 never occurs.
- Outputs are decoded registered from the state and change only on Clk rising edges.
- IDLE transitions:
  - rise_a only -> UP.
  - rise_b only -> DN.
  - both in same cycle -> stay IDLE (zero phase error, no pulse).
- UP transitions: rise_b (with or without rise_a) -> IDLE; rise_a only -> stay UP (frequency detection, saturating).
- DN transitions: rise_a (with or without rise_b) -> IDLE; rise_b only -> stay DN.
- Falling edges of A and B are ignored.
- Latency: QAN falls (or QB rises) on the (SYNC_STAGES+2)th rising Clk edge, counting the first edge that samples the input high as edge 1. Default: edge 4.
- Pulse width: equals the number of cycles between the synchronised A and B edges.
- Reset (synchronous): state=IDLE, so QAN=1 and QB=0 on the first Clk edge with Reset=1. Lock and all counters are cleared. Reset during UP or DN aborts the pulse.
- No combinational path from any input to any output.

Optional Feature:
- Macro LOCK_DET_EN.
- When defined:
  - Adds output Lock and a CNT_W-bit width counter. The counter clears on entry to UP or DN, increments each cycle in UP or DN, and saturates at all-ones.
  - A comparison completes on each return to IDLE, or on a simultaneous-edge event in IDLE (width 0).
  - On a completed comparison with width <= LOCK_TOL, the in-phase counter increments (saturating). Otherwise the in-phase counter clears and Lock deasserts on the next edge.
  - Lock=1 once the in-phase counter reaches LOCK_COUNT.
  - Any UP or DN dwell exceeding 4*LOCK_TOL cycles also deasserts Lock immediately.
- When undefined: no Lock port, no counters; the PFD behaviour is otherwise identical.

Test Plan:
- Reset with A=B=0, then with A=B=1 -> QAN=1, QB=0 after the first reset edge; no pulse after release, even with both inputs high.
- A rises, B rises 3 cycles later (SYNC_STAGES=2) -> QAN low for exactly 3 cycles starting at edge 4 after A is sampled; QB stays 0.
- B rises, A rises 5 cycles later -> QB high for exactly 5 cycles; QAN stays 1.
- A and B rise on the same sampling edge -> QAN=1 and QB=0 throughout.
- A toggles at twice B's rate -> QAN low continuously between B edges (saturates in UP); QB never 1.
- LOCK_DET_EN with LOCK_TOL=2, LOCK_COUNT=8:
  - 8 comparisons with 1-cycle skew -> Lock=1 after the 8th.
  - One 6-cycle skew -> Lock=0.
  - Reset mid-UP -> QAN=1 and Lock=0 next edge.

Source files
------------

// File: rtl/pfd_sync.sv
// Clocked tri-state phase-frequency detector with synchronised A/B edge inputs.
// Optional lock detector enabled by defining LOCK_DET_EN.
module pfd_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_TOL    = 2,
    parameter int LOCK_COUNT  = 8,
    parameter int CNT_W       = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic A,
    input  logic B,
    output logic QAN,
    output logic QB
`ifdef LOCK_DET_EN
    ,
    output logic Lock
`endif
);

    // Out-of-range parameters fail elaboration on an unknown module.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || CNT_W < 1 || LOCK_TOL < 0 ||
        LOCK_COUNT < 1 || LOCK_COUNT > (2**CNT_W) - 1) begin : g_bad_param
        pfd_sync_illegal_parameter u_bad ();
    end

    typedef enum logic [1:0] {IDLE, UP, DN} state_t;

    logic [SYNC_STAGES-1:0] sync_a, sync_b;
    logic                   hist_a, hist_b;
    logic                   rise_a, rise_b;
    state_t                 state, state_nxt;

    // Not reset: the chains keep tracking the inputs so a level already high
    // at reset release does not look like an edge.
    always_ff @(posedge Clk) begin
        sync_a <= {sync_a[SYNC_STAGES-2:0], A};
        sync_b <= {sync_b[SYNC_STAGES-2:0], B};
        hist_a <= sync_a[SYNC_STAGES-1];
        hist_b <= sync_b[SYNC_STAGES-1];
    end

    assign rise_a = sync_a[SYNC_STAGES-1] & ~hist_a;
    assign rise_b = sync_b[SYNC_STAGES-1] & ~hist_b;

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rise_a && !rise_b)      state_nxt = UP;
                else if (rise_b && !rise_a) state_nxt = DN;
            end
            UP:      if (rise_b) state_nxt = IDLE;
            DN:      if (rise_a) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            QAN <= 1'b1;
            QB  <= 1'b0;
        end else begin
            QAN <= (state != UP);
            QB  <= (state == DN);
        end
    end

`ifdef LOCK_DET_EN
    localparam logic [CNT_W-1:0] TOL       = CNT_W'(LOCK_TOL);
    localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(4 * LOCK_TOL);
    localparam logic [CNT_W-1:0] LOCK_N    = CNT_W'(LOCK_COUNT);

    logic [CNT_W-1:0] width_cnt, width_inc, inph_cnt, inph_inc, done_width;
    logic             busy, done, too_long;

    assign busy       = (state != IDLE);
    assign width_inc  = (&width_cnt) ? width_cnt : width_cnt + 1'b1;
    assign inph_inc   = (&inph_cnt)  ? inph_cnt  : inph_cnt + 1'b1;
    // Width of the pulse ending this cycle; a simultaneous edge in IDLE is width 0.
    assign done       = (busy && state_nxt == IDLE) || (!busy && rise_a && rise_b);
    assign done_width = busy ? width_inc : '0;
    assign too_long   = busy && (width_inc > DWELL_MAX);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            width_cnt <= '0;
            inph_cnt  <= '0;
            Lock      <= 1'b0;
        end else begin
            width_cnt <= busy ? width_inc : '0;
            if (too_long) begin
                inph_cnt <= '0;
                Lock     <= 1'b0;
            end else if (done) begin
                if (done_width <= TOL) begin
                    inph_cnt <= inph_inc;
                    Lock     <= (inph_inc >= LOCK_N);
                end else begin
                    inph_cnt <= '0;
                    Lock     <= 1'b0;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_pfd_sync.sv
// Directed bench for pfd_sync: edge-order table, reset, frequency and lock sequences.
module tb_pfd_sync;

    logic clk = 1'b0;
    logic reset, a, b, qan, qb;
`ifdef LOCK_DET_EN
    logic lock;
`endif
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pfd_sync dut (
        .Clk(clk), .Reset(reset), .A(a), .B(b), .QAN(qan), .QB(qb)
`ifdef LOCK_DET_EN
        , .Lock(lock)
`endif
    );

    typedef struct {
        int ta;        // cycle A is raised (-1: never)
        int tb;        // cycle B is raised
        int up_first;  // first recorded cycle with QAN=0 (-1: none)
        int up_w;
        int dn_first;
        int dn_w;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int up_first = -1, up_w = 0, dn_first = -1, dn_w = 0;
        for (int c = 0; c < 20; c++) begin
            if (c == v.ta) a = 1'b1;
            if (c == v.tb) b = 1'b1;
            tick();
            if (!qan) begin if (up_first < 0) up_first = c; up_w++; end
            if (qb)   begin if (dn_first < 0) dn_first = c; dn_w++; end
        end
        check($sformatf("vec%0d_up_first", idx), up_first, v.up_first);
        check($sformatf("vec%0d_up_width", idx), up_w, v.up_w);
        check($sformatf("vec%0d_dn_first", idx), dn_first, v.dn_first);
        check($sformatf("vec%0d_dn_width", idx), dn_w, v.dn_w);
        a = 1'b0;
        b = 1'b0;
        repeat (8) tick();
        check($sformatf("vec%0d_fall_idle", idx), {qan, qb}, 2'b10);
    endtask

`ifdef LOCK_DET_EN
    task automatic compare(input int ta, input int tb);
        for (int c = 0; c < 14; c++) begin
            if (c == ta) a = 1'b1;
            if (c == tb) b = 1'b1;
            tick();
        end
        a = 1'b0;
        b = 1'b0;
        repeat (6) tick();
    endtask
`endif

    initial begin
        vecs[0] = '{0,  3,  3, 3, -1, 0};
        vecs[1] = '{5,  0, -1, 0,  3, 5};
        vecs[2] = '{0,  0, -1, 0, -1, 0};
        vecs[3] = '{2,  3,  5, 1, -1, 0};
        vecs[4] = '{2,  1, -1, 0,  4, 1};
        vecs[5] = '{0, 10,  3, 10, -1, 0};

        // Reset with inputs low, then with both inputs high through release.
        a = 1'b0; b = 1'b0; reset = 1'b1;
        tick();
        check("reset_qan", qan, 1);
        check("reset_qb", qb, 0);
        repeat (4) tick();
        a = 1'b1; b = 1'b1;
        repeat (5) tick();
        check("reset_hi_out", {qan, qb}, 2'b10);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("rel_hi_c%0d", c), {qan, qb}, 2'b10);
        end
        a = 1'b0; b = 1'b0;
        repeat (6) tick();
        check("rel_fall_idle", {qan, qb}, 2'b10);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // A at twice B's rate: UP saturates across the extra A edge.
        for (int c = 0; c < 32; c++) begin
            if (c % 8 == 0) a = 1'b1;
            if (c % 8 == 4) a = 1'b0;
            if (c == 10 || c == 26) b = 1'b1;
            if (c == 18) b = 1'b0;
            tick();
            check($sformatf("freq_qan_c%0d", c), qan,
                  ((c >= 3 && c <= 12) || (c >= 19 && c <= 28)) ? 0 : 1);
            check($sformatf("freq_qb_c%0d", c), qb, 0);
        end
        a = 1'b0; b = 1'b0;
        repeat (8) tick();
        check("freq_end_idle", {qan, qb}, 2'b10);

`ifdef LOCK_DET_EN
        reset = 1'b1;
        repeat (4) tick();
        reset = 1'b0;
        tick();
        check("lock_after_reset", lock, 0);
        for (int k = 1; k <= 8; k++) begin
            compare(0, 1);
            check($sformatf("lock_cmp%0d", k), lock, (k == 8) ? 1 : 0);
        end
        compare(0, 6);
        check("lock_skew6", lock, 0);
        for (int k = 0; k < 8; k++) compare(0, 1);
        check("relock", lock, 1);
`endif

        // Reset in the middle of an UP pulse aborts it.
        a = 1'b1;
        repeat (4) tick();
        check("midup_qan_low", qan, 0);
        reset = 1'b1;
        tick();
        check("midup_reset_qan", qan, 1);
        check("midup_reset_qb", qb, 0);
`ifdef LOCK_DET_EN
        check("midup_reset_lock", lock, 0);
`endif
        repeat (3) tick();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("midup_rel_c%0d", c), {qan, qb}, 2'b10);
        end
        a = 1'b0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
